mpt_plb: RTL and testbench

- Parametrised Protection Lookaside Buffer (PLB) for the MPT checker. It caches permission results for supervisor physical addresses, tagged by SDID.
- Successor to the fixed 42-bit, 4 KiB-only PLB entry format. Entry count, SPA width and SDID width are now parameters.
- Entries cover 4 KiB, 4 MiB or 1 GiB regions, so a single MPTL2 leaf or 4M-page result fills one entry.
- Supports global flush and per-SDID flush. Sits between the core's access path and the MPT walker, which refills it on miss.

---
 rtl/mpt_plb.sv | 235 +++++++++++++++++++++++
 tb/tb_mpt_plb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpt_plb.sv
// mpt_plb: fully-associative protection lookaside buffer for the MPT checker (4K/4M/1G entries, SDID tagged).
// Optional hit/miss statistics counters are built when MPT_PLB_STATS_EN is defined.
module mpt_plb #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned PLEN        = 34,
  parameter int unsigned SDID_LEN    = 6,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                lookup_valid_i,
  output logic                lookup_ready_o,
  input  logic [SDID_LEN-1:0] lookup_sdid_i,
  input  logic [PLEN-1:0]     lookup_spa_i,
  input  logic [1:0]          lookup_access_i,
  output logic                resp_valid_o,
  output logic                resp_hit_o,
  output logic [1:0]          resp_perm_o,
  output logic                resp_allowed_o,
  input  logic                refill_valid_i,
  input  logic [SDID_LEN-1:0] refill_sdid_i,
  input  logic [PLEN-1:0]     refill_spa_i,
  input  logic [1:0]          refill_size_i,
  input  logic [1:0]          refill_perm_i,
  input  logic                flush_i,
  input  logic                flush_sdid_en_i,
  input  logic [SDID_LEN-1:0] flush_sdid_i,
`ifdef MPT_PLB_STATS_EN
  input  logic                stats_clr_i,
  output logic [CNT_W-1:0]    hit_cnt_o,
  output logic [CNT_W-1:0]    miss_cnt_o,
`endif
  output logic                flush_done_o
);

  localparam int unsigned TAG_W = PLEN - 12;
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  localparam logic [1:0] SZ_4M   = 2'b01;
  localparam logic [1:0] SZ_1G   = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e state_q, state_d;

  logic [NUM_ENTRIES-1:0]               entry_valid_q;
  logic [NUM_ENTRIES-1:0][SDID_LEN-1:0] entry_sdid_q;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0]    entry_tag_q;
  logic [NUM_ENTRIES-1:0][1:0]          entry_size_q;
  logic [NUM_ENTRIES-1:0][1:0]          entry_perm_q;

  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                flush_sdid_en_q;
  logic [SDID_LEN-1:0] flush_sdid_q;
  logic                flush_done_q;

  logic       resp_valid_q, resp_hit_q, resp_allowed_q;
  logic [1:0] resp_perm_q;

  logic [NUM_ENTRIES-1:0] hit_vec, same_vec, flush_vec;
  logic                   hit_any, same_any, free_any;
  logic [IDX_W-1:0]       hit_idx, same_idx, free_idx, wr_idx;
  logic [TAG_W-1:0]       lookup_tag, refill_tag;
  logic                   lookup_fire, refill_en;

  // Tag bits below the entry granularity are don't-care for matching and stored as zero.
  function automatic logic [TAG_W-1:0] size_mask(input logic [1:0] size);
    logic [TAG_W-1:0] m;
    m = '1;
    if (size == SZ_4M) begin
      m[9:0] = '0;
    end else if (size == SZ_1G) begin
      m[17:0] = '0;
    end
    return m;
  endfunction

  // perm encoding: 01 RX, 10 RW, 11 RWX.
  function automatic logic access_ok(input logic [1:0] access, input logic [1:0] perm);
    logic ok;
    ok = 1'b0;
    case (access)
      2'b01:   ok = (perm != 2'b00);
      2'b10:   ok = perm[1];
      2'b11:   ok = perm[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign lookup_tag = lookup_spa_i[PLEN-1:12];
  assign refill_tag = refill_spa_i[PLEN-1:12] & size_mask(refill_size_i);

  assign lookup_ready_o = rst_ni && (state_q == RUN) && !flush_i;
  assign lookup_fire    = lookup_valid_i && lookup_ready_o;
  assign refill_en      = refill_valid_i && !flush_i && (state_q == RUN) && (refill_size_i != SZ_RSVD);

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
    assign hit_vec[gi] = entry_valid_q[gi] && (entry_sdid_q[gi] == lookup_sdid_i) &&
                         (((entry_tag_q[gi] ^ lookup_tag) & size_mask(entry_size_q[gi])) == '0);
    assign same_vec[gi] = entry_valid_q[gi] && (entry_sdid_q[gi] == refill_sdid_i) &&
                          (entry_size_q[gi] == refill_size_i) && (entry_tag_q[gi] == refill_tag);
    assign flush_vec[gi] = !flush_sdid_en_q || (entry_sdid_q[gi] == flush_sdid_q);
  end

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    same_any = 1'b0;
    same_idx = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (same_vec[i]) begin
        same_any = 1'b1;
        same_idx = IDX_W'(i);
      end
      if (!entry_valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    wr_idx = ptr_q;
    ptr_d  = ptr_q;
    if (same_any) begin
      wr_idx = same_idx;
    end else if (free_any) begin
      wr_idx = free_idx;
    end else if (refill_en) begin
      ptr_d = ptr_q + IDX_W'(1);
    end
    if (state_q == FLUSH && !flush_sdid_en_q) begin
      ptr_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_i) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= RUN;
      ptr_q           <= '0;
      flush_sdid_en_q <= 1'b0;
      flush_sdid_q    <= '0;
      flush_done_q    <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_perm_q     <= 2'b00;
      resp_allowed_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      flush_done_q <= (state_q == FLUSH);
      if (state_q == RUN && flush_i) begin
        flush_sdid_en_q <= flush_sdid_en_i;
        flush_sdid_q    <= flush_sdid_i;
      end
      resp_valid_q   <= lookup_fire;
      resp_hit_q     <= lookup_fire && hit_any;
      resp_perm_q    <= (lookup_fire && hit_any) ? entry_perm_q[hit_idx] : 2'b00;
      resp_allowed_q <= lookup_fire && hit_any && access_ok(lookup_access_i, entry_perm_q[hit_idx]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_valid_q <= '0;
      entry_sdid_q  <= '0;
      entry_tag_q   <= '0;
      entry_size_q  <= '0;
      entry_perm_q  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (state_q == FLUSH) begin
          if (flush_vec[i]) entry_valid_q[i] <= 1'b0;
        end else if (refill_en && wr_idx == IDX_W'(i)) begin
          entry_valid_q[i] <= 1'b1;
          entry_sdid_q[i]  <= refill_sdid_i;
          entry_tag_q[i]   <= refill_tag;
          entry_size_q[i]  <= refill_size_i;
          entry_perm_q[i]  <= refill_perm_i;
        end
      end
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_hit_o     = resp_hit_q;
  assign resp_perm_o    = resp_perm_q;
  assign resp_allowed_o = resp_allowed_q;
  assign flush_done_o   = flush_done_q;

`ifdef MPT_PLB_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (stats_clr_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (resp_valid_q) begin
      if (resp_hit_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (!resp_hit_q && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

  logic unused_spa_low;
  assign unused_spa_low = ^{lookup_spa_i[11:0], refill_spa_i[11:0]};

endmodule

// File: tb/tb_mpt_plb.sv
// tb_mpt_plb: directed self-checking bench for mpt_plb (default parameters).
// Stats checks are compiled in when MPT_PLB_STATS_EN is defined.
module tb_mpt_plb;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lookup_valid_i;
  logic        lookup_ready_o;
  logic [5:0]  lookup_sdid_i;
  logic [33:0] lookup_spa_i;
  logic [1:0]  lookup_access_i;
  logic        resp_valid_o, resp_hit_o, resp_allowed_o;
  logic [1:0]  resp_perm_o;
  logic        refill_valid_i;
  logic [5:0]  refill_sdid_i;
  logic [33:0] refill_spa_i;
  logic [1:0]  refill_size_i, refill_perm_i;
  logic        flush_i, flush_sdid_en_i;
  logic [5:0]  flush_sdid_i;
  logic        flush_done_o;
`ifdef MPT_PLB_STATS_EN
  logic        stats_clr_i;
  logic [15:0] hit_cnt_o, miss_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  mpt_plb dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_sdid_i(lookup_sdid_i), .lookup_spa_i(lookup_spa_i), .lookup_access_i(lookup_access_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_perm_o(resp_perm_o),
    .resp_allowed_o(resp_allowed_o),
    .refill_valid_i(refill_valid_i), .refill_sdid_i(refill_sdid_i), .refill_spa_i(refill_spa_i),
    .refill_size_i(refill_size_i), .refill_perm_i(refill_perm_i),
    .flush_i(flush_i), .flush_sdid_en_i(flush_sdid_en_i), .flush_sdid_i(flush_sdid_i),
`ifdef MPT_PLB_STATS_EN
    .stats_clr_i(stats_clr_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
`endif
    .flush_done_o(flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_refill(input logic [5:0] sd, input logic [33:0] spa, input logic [1:0] sz,
                           input logic [1:0] perm);
    refill_valid_i = 1'b1;
    refill_sdid_i  = sd;
    refill_spa_i   = spa;
    refill_size_i  = sz;
    refill_perm_i  = perm;
    tick();
    refill_valid_i = 1'b0;
    $display("refill sdid=%0d spa=%h size=%0d perm=%0d", sd, spa, sz, perm);
  endtask

  task automatic do_lookup(input string nm, input logic [5:0] sd, input logic [33:0] spa,
                           input logic [1:0] acc, input logic exp_hit, input logic [1:0] exp_perm,
                           input logic exp_allowed);
    lookup_valid_i  = 1'b1;
    lookup_sdid_i   = sd;
    lookup_spa_i    = spa;
    lookup_access_i = acc;
    tick();
    lookup_valid_i = 1'b0;
    $display("lookup %s sdid=%0d spa=%h acc=%0d -> hit=%0d perm=%0d allowed=%0d",
             nm, sd, spa, acc, resp_hit_o, resp_perm_o, resp_allowed_o);
    check({nm, ".valid"},   64'(resp_valid_o),   64'(1'b1));
    check({nm, ".hit"},     64'(resp_hit_o),     64'(exp_hit));
    check({nm, ".perm"},    64'(resp_perm_o),    64'(exp_perm));
    check({nm, ".allowed"}, 64'(resp_allowed_o), 64'(exp_allowed));
  endtask

  // Flush control inputs are scrambled after the request cycle so only captured values may matter.
  task automatic do_flush(input string nm, input logic en, input logic [5:0] sd, input logic refill_in_flush);
    flush_i         = 1'b1;
    flush_sdid_en_i = en;
    flush_sdid_i    = sd;
    #1;
    check({nm, ".rdy_req"}, 64'(lookup_ready_o), 64'(1'b0));
    tick();
    flush_i         = 1'b0;
    refill_valid_i  = 1'b0;
    flush_sdid_en_i = ~en;
    flush_sdid_i    = ~sd;
    if (refill_in_flush) begin
      refill_valid_i = 1'b1;
      refill_sdid_i  = 6'd4;
      refill_spa_i   = 34'h0_0000_8000;
      refill_size_i  = 2'b00;
      refill_perm_i  = 2'b11;
    end
    #1;
    check({nm, ".rdy_flush"},  64'(lookup_ready_o), 64'(1'b0));
    check({nm, ".done_early"}, 64'(flush_done_o),   64'(1'b0));
    tick();
    refill_valid_i = 1'b0;
    check({nm, ".done"},      64'(flush_done_o),   64'(1'b1));
    check({nm, ".rdy_after"}, 64'(lookup_ready_o), 64'(1'b1));
    tick();
    check({nm, ".done_pulse"}, 64'(flush_done_o), 64'(1'b0));
    $display("flush %s en=%0d sdid=%0d", nm, en, sd);
  endtask

  initial begin
    rst_ni = 1'b0;
    lookup_valid_i = 1'b0; lookup_sdid_i = '0; lookup_spa_i = '0; lookup_access_i = '0;
    refill_valid_i = 1'b0; refill_sdid_i = '0; refill_spa_i = '0; refill_size_i = '0; refill_perm_i = '0;
    flush_i = 1'b0; flush_sdid_en_i = 1'b0; flush_sdid_i = '0;
`ifdef MPT_PLB_STATS_EN
    stats_clr_i = 1'b0;
`endif
    repeat (3) tick();
    check("rst.resp_valid", 64'(resp_valid_o), 64'(1'b0));
    check("rst.ready",      64'(lookup_ready_o), 64'(1'b0));
    check("rst.done",       64'(flush_done_o), 64'(1'b0));
    rst_ni = 1'b1;
    tick();
    check("post_rst.ready", 64'(lookup_ready_o), 64'(1'b1));
    check("post_rst.resp",  64'(resp_valid_o), 64'(1'b0));
    do_lookup("empty", 6'd3, 34'h0_1234_5000, 2'b01, 1'b0, 2'b00, 1'b0);

    // 4K, 1G, 4M coverage and reserved size.
    do_refill(6'd3, 34'h0_1234_5000, 2'b00, 2'b10);
    do_lookup("4k_wr",   6'd3, 34'h0_1234_5ABC, 2'b10, 1'b1, 2'b10, 1'b1);
    do_lookup("4k_ex",   6'd3, 34'h0_1234_5ABC, 2'b11, 1'b1, 2'b10, 1'b0);
    do_lookup("4k_none", 6'd3, 34'h0_1234_5ABC, 2'b00, 1'b1, 2'b10, 1'b0);
    do_lookup("4k_next", 6'd3, 34'h0_1234_6000, 2'b01, 1'b0, 2'b00, 1'b0);
    do_refill(6'd1, 34'h1_4000_0000, 2'b10, 2'b01);
    do_lookup("1g_rd",   6'd1, 34'h1_7FFF_FFF0, 2'b01, 1'b1, 2'b01, 1'b1);
    do_lookup("1g_wr",   6'd1, 34'h1_7FFF_FFF0, 2'b10, 1'b1, 2'b01, 1'b0);
    do_lookup("1g_sdid", 6'd2, 34'h1_7FFF_FFF0, 2'b01, 1'b0, 2'b00, 1'b0);
    do_lookup("1g_hi",   6'd1, 34'h1_8000_0000, 2'b01, 1'b0, 2'b00, 1'b0);
    do_lookup("1g_lo",   6'd1, 34'h1_3FFF_FFFF, 2'b01, 1'b0, 2'b00, 1'b0);
    do_refill(6'd1, 34'h0_0040_1234, 2'b01, 2'b11);
    do_lookup("4m_ex",   6'd1, 34'h0_007F_FFFF, 2'b11, 1'b1, 2'b11, 1'b1);
    do_lookup("4m_hi",   6'd1, 34'h0_0080_0000, 2'b01, 1'b0, 2'b00, 1'b0);
    do_refill(6'd4, 34'h0_0000_5000, 2'b11, 2'b11);
    do_lookup("rsvd",    6'd4, 34'h0_0000_5000, 2'b01, 1'b0, 2'b00, 1'b0);

    do_flush("gflush", 1'b0, 6'd0, 1'b0);
    do_lookup("gf_4k", 6'd3, 34'h0_1234_5000, 2'b01, 1'b0, 2'b00, 1'b0);
    do_lookup("gf_1g", 6'd1, 34'h1_4000_0000, 2'b01, 1'b0, 2'b00, 1'b0);

    // Replacement: 8 fills, 9th evicts entry 0, in-place update keeps pointer at 1.
    for (int i = 1; i <= 8; i++) do_refill(6'd5, 34'(i) << 12, 2'b00, 2'b11);
    do_refill(6'd5, 34'h0_0000_9000, 2'b00, 2'b11);
    do_lookup("rr_evict", 6'd5, 34'h0_0000_1000, 2'b01, 1'b0, 2'b00, 1'b0);
    do_lookup("rr_keep",  6'd5, 34'h0_0000_2000, 2'b01, 1'b1, 2'b11, 1'b1);
    do_lookup("rr_new",   6'd5, 34'h0_0000_9000, 2'b10, 1'b1, 2'b11, 1'b1);
    do_refill(6'd5, 34'h0_0000_3000, 2'b00, 2'b01);
    do_lookup("rr_upd",   6'd5, 34'h0_0000_3000, 2'b10, 1'b1, 2'b01, 1'b0);
    do_lookup("rr_upd2",  6'd5, 34'h0_0000_2000, 2'b01, 1'b1, 2'b11, 1'b1);
    do_refill(6'd5, 34'h0_0000_A000, 2'b00, 2'b11);
    do_lookup("rr_ptr1",  6'd5, 34'h0_0000_2000, 2'b01, 1'b0, 2'b00, 1'b0);
    do_lookup("rr_ptr1b", 6'd5, 34'h0_0000_4000, 2'b01, 1'b1, 2'b11, 1'b1);

    // SDID flush, with lowest-index priority between overlapping entries.
    do_flush("gflush2", 1'b0, 6'd5, 1'b0);
    do_refill(6'd1, 34'h0_0001_0000, 2'b00, 2'b11);
    do_refill(6'd2, 34'h0_0001_0000, 2'b00, 2'b10);
    do_refill(6'd7, 34'h0_4000_0000, 2'b00, 2'b10);
    do_refill(6'd7, 34'h0_4000_0000, 2'b10, 2'b01);
    do_lookup("prio_low", 6'd7, 34'h0_4000_0123, 2'b01, 1'b1, 2'b10, 1'b1);
    do_lookup("prio_1g",  6'd7, 34'h0_4000_1000, 2'b11, 1'b1, 2'b01, 1'b1);
    lookup_valid_i = 1'b1; lookup_sdid_i = 6'd1; lookup_spa_i = 34'h0_0001_0000; lookup_access_i = 2'b01;
    tick();
    lookup_valid_i = 1'b0;
    check("inflight.hit", 64'(resp_hit_o), 64'(1'b1));
    do_flush("sflush", 1'b1, 6'd1, 1'b0);
    do_lookup("sf_sd1", 6'd1, 34'h0_0001_0000, 2'b01, 1'b0, 2'b00, 1'b0);
    do_lookup("sf_sd2", 6'd2, 34'h0_0001_0000, 2'b10, 1'b1, 2'b10, 1'b1);
    do_lookup("sf_sd7", 6'd7, 34'h0_4000_0000, 2'b01, 1'b1, 2'b10, 1'b1);

    // Collisions: refill with flush_i, refill during FLUSH, lookup with same-address refill.
    refill_valid_i = 1'b1; refill_sdid_i = 6'd4; refill_spa_i = 34'h0_0000_7000;
    refill_size_i = 2'b00; refill_perm_i = 2'b11;
    do_flush("cflush", 1'b1, 6'd9, 1'b1);
    do_lookup("col_flush",  6'd4, 34'h0_0000_7000, 2'b01, 1'b0, 2'b00, 1'b0);
    do_lookup("col_inflsh", 6'd4, 34'h0_0000_8000, 2'b01, 1'b0, 2'b00, 1'b0);
    do_lookup("col_keep",   6'd2, 34'h0_0001_0000, 2'b01, 1'b1, 2'b10, 1'b1);
    lookup_valid_i = 1'b1; lookup_sdid_i = 6'd4; lookup_spa_i = 34'h0_0000_6000; lookup_access_i = 2'b01;
    refill_valid_i = 1'b1; refill_sdid_i = 6'd4; refill_spa_i = 34'h0_0000_6000;
    refill_size_i = 2'b00; refill_perm_i = 2'b11;
    tick();
    lookup_valid_i = 1'b0; refill_valid_i = 1'b0;
    check("col_same.valid", 64'(resp_valid_o), 64'(1'b1));
    check("col_same.hit",   64'(resp_hit_o),   64'(1'b0));
    do_lookup("col_after", 6'd4, 34'h0_0000_6000, 2'b01, 1'b1, 2'b11, 1'b1);

    // Reset mid-stream with a lookup in flight.
    lookup_valid_i = 1'b1; lookup_sdid_i = 6'd4; lookup_spa_i = 34'h0_0000_6000; lookup_access_i = 2'b01;
    #2 rst_ni = 1'b0;
    #1;
    check("mrst.resp_valid", 64'(resp_valid_o), 64'(1'b0));
    check("mrst.ready",      64'(lookup_ready_o), 64'(1'b0));
    tick();
    check("mrst.resp_hold",  64'(resp_valid_o), 64'(1'b0));
    lookup_valid_i = 1'b0;
    rst_ni = 1'b1;
    tick();
    check("mrst.done", 64'(flush_done_o), 64'(1'b0));
    do_lookup("mrst_a", 6'd4, 34'h0_0000_6000, 2'b01, 1'b0, 2'b00, 1'b0);
    do_lookup("mrst_b", 6'd2, 34'h0_0001_0000, 2'b01, 1'b0, 2'b00, 1'b0);

`ifdef MPT_PLB_STATS_EN
    stats_clr_i = 1'b1;
    tick();
    stats_clr_i = 1'b0;
    check("stats.clr0_hit",  64'(hit_cnt_o),  64'd0);
    check("stats.clr0_miss", 64'(miss_cnt_o), 64'd0);
    do_refill(6'd4, 34'h0_0000_6000, 2'b00, 2'b11);
    for (int i = 0; i < 3; i++) do_lookup("st_hit", 6'd4, 34'h0_0000_6000, 2'b01, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 2; i++) do_lookup("st_miss", 6'd4, 34'h0_0000_F000, 2'b01, 1'b0, 2'b00, 1'b0);
    tick();
    check("stats.hit",  64'(hit_cnt_o),  64'd3);
    check("stats.miss", 64'(miss_cnt_o), 64'd2);
    stats_clr_i = 1'b1;
    tick();
    stats_clr_i = 1'b0;
    check("stats.clr_hit",  64'(hit_cnt_o),  64'd0);
    check("stats.clr_miss", 64'(miss_cnt_o), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
